// File: rtl/usb_pkg.sv
// Shared definitions for the USB transmit path: packet geometry, default
// FT245 write timing and the transmit FSM state encoding.
package usb_pkg;

  localparam int PACKET_BYTES   = 4;
  localparam int WR_PULSE_DEF   = 3;
  localparam int TXE_SETTLE_DEF = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_FETCH,
    ST_WAITB,
    ST_SETUP,
    ST_STROBE,
    ST_HOLD,
    ST_SETTLE
  } tx_state_e;

endpackage

// File: rtl/packet_fifo_ram.sv
// Simple dual-port packet store with a one-cycle registered read so it maps
// onto block RAM; deliberately has no reset.
module packet_fifo_ram
  import usb_pkg::*;
#(
  parameter int DEPTH_LOG2 = 9
) (
  input  logic                        clk_i,
  input  logic                        wr_en_i,
  input  logic [DEPTH_LOG2-1:0]       wr_addr_i,
  input  logic [PACKET_BYTES*8-1:0]   wr_data_i,
  input  logic                        rd_en_i,
  input  logic [DEPTH_LOG2-1:0]       rd_addr_i,
  output logic [PACKET_BYTES*8-1:0]   rd_data_o
);

  logic [PACKET_BYTES*8-1:0] mem [2**DEPTH_LOG2];
  logic [PACKET_BYTES*8-1:0] rd_data_q;

  always_ff @(posedge clk_i) begin
    if (wr_en_i) mem[wr_addr_i] <= wr_data_i;
    if (rd_en_i) rd_data_q <= mem[rd_addr_i];
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/usb_tx_packet_fifo.sv
// Packet FIFO in front of the FT245 write port: stores 32-bit trace packets
// and writes them out LSB byte first, dropping (and counting) pushes when full.
module usb_tx_packet_fifo
  import usb_pkg::*;
#(
  parameter int DEPTH_LOG2 = 9,
  parameter int WR_PULSE   = WR_PULSE_DEF,
  parameter int TXE_SETTLE = TXE_SETTLE_DEF
) (
  input  logic                  mclk,
  input  logic                  reset,
  input  logic [31:0]           packet_data,
  input  logic                  packet_strobe,
  input  logic                  usb_txe_n,
  input  logic                  tx_inhibit,
  output logic [7:0]            usb_d_out,
  output logic                  usb_d_oe,
  output logic                  usb_wr_n,
  output logic                  tx_active,
  output logic [DEPTH_LOG2:0]   fifo_level,
  output logic                  overflow,
  output logic [7:0]            drop_count
);

  localparam logic [DEPTH_LOG2:0] FullCount = (DEPTH_LOG2+1)'(2**DEPTH_LOG2);

  logic [DEPTH_LOG2-1:0] wr_ptr_q, rd_ptr_q;
  logic [DEPTH_LOG2:0]   count_q, count_d;
  logic                  overflow_q;
  logic [7:0]            drop_count_q;
  logic                  txe_meta_q, txe_sync_q;
  tx_state_e             state_q, state_d;
  logic [31:0]           shift_q, shift_d;
  logic [1:0]            byte_idx_q, byte_idx_d;
  logic [7:0]            timer_q, timer_d;
  logic [7:0]            d_out_q;
  logic                  oe_q, wr_n_q, active_q;
  logic [31:0]           rd_data;
  logic                  full, empty, push_ok, pop, drive;

  assign full    = (count_q == FullCount);
  assign empty   = (count_q == '0);
  assign pop     = (state_q == ST_LOAD);
  assign push_ok = packet_strobe && !full;

  packet_fifo_ram #(.DEPTH_LOG2(DEPTH_LOG2)) u_ram (
    .clk_i     (mclk),
    .wr_en_i   (push_ok),
    .wr_addr_i (wr_ptr_q),
    .wr_data_i (packet_data),
    .rd_en_i   (pop),
    .rd_addr_i (rd_ptr_q),
    .rd_data_o (rd_data)
  );

  always_comb begin
    count_d = count_q;
    if (push_ok && !pop)      count_d = count_q + 1'b1;
    else if (!push_ok && pop) count_d = count_q - 1'b1;
  end

  always_ff @(posedge mclk) begin
    if (reset) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      overflow_q   <= 1'b0;
      drop_count_q <= '0;
      txe_meta_q   <= 1'b1;
      txe_sync_q   <= 1'b1;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)     rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
      // Fullness comes from the registered count, so a same-cycle pop never rescues a push.
      if (packet_strobe && full) begin
        overflow_q <= 1'b1;
        if (drop_count_q != 8'hFF) drop_count_q <= drop_count_q + 8'd1;
      end
      txe_meta_q <= usb_txe_n;
      txe_sync_q <= txe_meta_q;
    end
  end

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    byte_idx_d = byte_idx_q;
    timer_d    = timer_q;
    case (state_q)
      ST_IDLE:   if (!empty) state_d = ST_LOAD;
      ST_LOAD: begin
        byte_idx_d = '0;
        state_d    = ST_FETCH;
      end
      ST_FETCH: begin
        shift_d = rd_data;
        state_d = ST_WAITB;
      end
      ST_WAITB:  if (!txe_sync_q && !tx_inhibit) state_d = ST_SETUP;
      ST_SETUP: begin
        timer_d = '0;
        state_d = ST_STROBE;
      end
      ST_STROBE: begin
        if (timer_q == 8'(WR_PULSE - 1)) state_d = ST_HOLD;
        else                             timer_d = timer_q + 8'd1;
      end
      ST_HOLD: begin
        timer_d = '0;
        state_d = ST_SETTLE;
      end
      ST_SETTLE: begin
        // The settle gap lets the synchronized TXE catch up before the next byte.
        if (timer_q == 8'(TXE_SETTLE - 1)) begin
          if (byte_idx_q != 2'(PACKET_BYTES - 1)) begin
            byte_idx_d = byte_idx_q + 2'd1;
            shift_d    = {8'h00, shift_q[31:8]};
            state_d    = ST_WAITB;
          end else if (!empty) begin
            state_d = ST_LOAD;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          timer_d = timer_q + 8'd1;
        end
      end
      default:   state_d = ST_IDLE;
    endcase
  end

  assign drive = (state_d == ST_SETUP) || (state_d == ST_STROBE) || (state_d == ST_HOLD);

  // Pin-facing outputs are registered from the next state so the FT245 sees glitch-free strobes.
  always_ff @(posedge mclk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      shift_q    <= '0;
      byte_idx_q <= '0;
      timer_q    <= '0;
      d_out_q    <= '0;
      oe_q       <= 1'b0;
      wr_n_q     <= 1'b1;
      active_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      byte_idx_q <= byte_idx_d;
      timer_q    <= timer_d;
      d_out_q    <= drive ? shift_q[7:0] : 8'h00;
      oe_q       <= drive;
      wr_n_q     <= (state_d != ST_STROBE);
      active_q   <= drive;
    end
  end

  assign usb_d_out  = d_out_q;
  assign usb_d_oe   = oe_q;
  assign usb_wr_n   = wr_n_q;
  assign tx_active  = active_q;
  assign fifo_level = count_q;
  assign overflow   = overflow_q;
  assign drop_count = drop_count_q;

endmodule

// File: tb/tb_usb_tx_packet_fifo.sv
// Directed bench for usb_tx_packet_fifo: a byte scoreboard fed on every accepted
// push is drained and compared on each falling edge of usb_wr_n.
module tb_usb_tx_packet_fifo;

  logic        mclk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] packet_data = '0;
  logic        packet_strobe = 1'b0;
  logic        usb_txe_n = 1'b0;
  logic        tx_inhibit = 1'b0;
  logic [7:0]  usb_d_out;
  logic        usb_d_oe, usb_wr_n, tx_active, overflow;
  logic [9:0]  fifo_level;
  logic [7:0]  drop_count;

  int checks = 0;
  int errors = 0;
  logic [7:0] expQ[$];
  logic [7:0] expByte;
  logic       monPrevWr = 1'b1;

  usb_tx_packet_fifo dut (
    .mclk          (mclk),
    .reset         (reset),
    .packet_data   (packet_data),
    .packet_strobe (packet_strobe),
    .usb_txe_n     (usb_txe_n),
    .tx_inhibit    (tx_inhibit),
    .usb_d_out     (usb_d_out),
    .usb_d_oe      (usb_d_oe),
    .usb_wr_n      (usb_wr_n),
    .tx_active     (tx_active),
    .fifo_level    (fifo_level),
    .overflow      (overflow),
    .drop_count    (drop_count)
  );

  always #5 mclk = ~mclk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: observed timeout required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [31:0] data, input bit accepted);
    packet_data   = data;
    packet_strobe = 1'b1;
    if (accepted)
      for (int b = 0; b < 4; b++) expQ.push_back(data[8*b +: 8]);
    @(negedge mclk);
    packet_strobe = 1'b0;
  endtask

  task automatic waitFalls(input int n, input string tag);
    int   seen = 0;
    int   cyc = 0;
    logic prev;
    prev = usb_wr_n;
    while (seen < n && cyc < 400) begin
      @(negedge mclk);
      cyc++;
      if (prev && !usb_wr_n) seen++;
      prev = usb_wr_n;
    end
    checkOutput(tag, 32'(seen), 32'(n));
  endtask

  task automatic waitHigh(input string tag);
    int c = 0;
    while (usb_wr_n !== 1'b1 && c < 20) begin
      @(negedge mclk);
      c++;
    end
    checkOutput(tag, 32'(usb_wr_n), 32'h1);
  endtask

  task automatic countFalls(input int cycles, output int falls);
    logic prev;
    falls = 0;
    prev = usb_wr_n;
    for (int i = 0; i < cycles; i++) begin
      @(negedge mclk);
      if (prev && !usb_wr_n) falls++;
      prev = usb_wr_n;
    end
  endtask

  // Scoreboard consumer: every new write strobe must carry the next expected byte.
  always @(negedge mclk) begin
    if (monPrevWr === 1'b1 && usb_wr_n === 1'b0) begin
      if (expQ.size() == 0) begin
        checks++;
        errors++;
        $error("[TB] FAIL unexpected_strobe: observed byte 0x%0h expected no strobe", usb_d_out);
      end else begin
        expByte = expQ.pop_front();
        checkOutput("byte_data", 32'(usb_d_out), 32'(expByte));
        checkOutput("byte_oe", 32'(usb_d_oe), 32'h1);
      end
    end
    monPrevWr = usb_wr_n;
  end

  initial begin
    int   falls;
    int   nFalls;
    int   fallCyc[4];
    logic prevW;

    reset = 1'b1;
    repeat (4) @(negedge mclk);
    checkOutput("rst_wr_n", 32'(usb_wr_n), 32'h1);
    checkOutput("rst_oe", 32'(usb_d_oe), 32'h0);
    checkOutput("rst_d_out", 32'(usb_d_out), 32'h0);
    checkOutput("rst_active", 32'(tx_active), 32'h0);
    checkOutput("rst_level", 32'(fifo_level), 32'h0);
    checkOutput("rst_overflow", 32'(overflow), 32'h0);
    checkOutput("rst_drops", 32'(drop_count), 32'h0);
    reset = 1'b0;
    repeat (3) @(negedge mclk);

    // Single packet: cycle-accurate latency and byte spacing.
    applyStimulus(32'hA1B2C3D4, 1'b1);
    nFalls = 0;
    prevW  = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      if (k == 1) checkOutput("level_after_push", 32'(fifo_level), 32'h1);
      if (k == 3) checkOutput("level_after_pop", 32'(fifo_level), 32'h0);
      if (k == 5) begin
        checkOutput("setup_oe", 32'(usb_d_oe), 32'h1);
        checkOutput("setup_data", 32'(usb_d_out), 32'hD4);
        checkOutput("setup_wr_n", 32'(usb_wr_n), 32'h1);
      end
      if (k == 8) checkOutput("strobe_last_cycle", 32'(usb_wr_n), 32'h0);
      if (k == 9) begin
        checkOutput("hold_wr_n", 32'(usb_wr_n), 32'h1);
        checkOutput("hold_oe", 32'(usb_d_oe), 32'h1);
      end
      if (prevW && !usb_wr_n) begin
        if (nFalls < 4) fallCyc[nFalls] = k;
        nFalls++;
      end
      prevW = usb_wr_n;
      @(negedge mclk);
    end
    checkOutput("single_fall_count", 32'(nFalls), 32'h4);
    for (int i = 0; i < 4; i++) checkOutput("byte_fall_cycle", 32'(fallCyc[i]), 32'(6 + 8 * i));
    checkOutput("single_drained", 32'(fifo_level), 32'h0);

    // TXE deasserts during the HOLD of byte 1.
    applyStimulus(32'h44332211, 1'b1);
    waitFalls(2, "txe_byte1_strobe");
    waitHigh("txe_byte1_hold");
    usb_txe_n = 1'b1;
    countFalls(20, falls);
    checkOutput("txe_stall_falls", 32'(falls), 32'h0);
    checkOutput("txe_stall_active", 32'(tx_active), 32'h0);
    usb_txe_n = 1'b0;
    repeat (3) @(negedge mclk);
    checkOutput("txe_resume_wait", 32'(usb_wr_n), 32'h1);
    @(negedge mclk);
    checkOutput("txe_resume_strobe", 32'(usb_wr_n), 32'h0);
    waitFalls(1, "txe_byte3");
    repeat (12) @(negedge mclk);
    checkOutput("txe_drained", 32'(fifo_level), 32'h0);
    checkOutput("txe_queue_empty", 32'(expQ.size()), 32'h0);

    // tx_inhibit raised mid-strobe.
    applyStimulus(32'hDEADBEEF, 1'b1);
    waitFalls(1, "inh_byte0");
    tx_inhibit = 1'b1;
    repeat (2) @(negedge mclk);
    checkOutput("inh_strobe_continues", 32'(usb_wr_n), 32'h0);
    @(negedge mclk);
    checkOutput("inh_byte_completes", 32'(usb_wr_n), 32'h1);
    countFalls(20, falls);
    checkOutput("inh_stall_falls", 32'(falls), 32'h0);
    tx_inhibit = 1'b0;
    @(negedge mclk);
    checkOutput("inh_release_setup", 32'(usb_wr_n), 32'h1);
    @(negedge mclk);
    checkOutput("inh_release_strobe", 32'(usb_wr_n), 32'h0);
    waitFalls(2, "inh_rest");
    repeat (12) @(negedge mclk);
    checkOutput("inh_queue_empty", 32'(expQ.size()), 32'h0);

    // Fill with the FSM parked on a primer packet, then overflow and saturate.
    usb_txe_n = 1'b1;
    repeat (4) @(negedge mclk);
    applyStimulus(32'h0F0E0D0C, 1'b1);
    repeat (10) @(negedge mclk);
    checkOutput("primer_popped", 32'(fifo_level), 32'h0);
    for (int i = 0; i < 513; i++)
      applyStimulus({8'(i + 3), 8'(i + 2), 8'(i + 1), 8'(i)}, i < 512);
    checkOutput("full_level", 32'(fifo_level), 32'd512);
    checkOutput("full_overflow", 32'(overflow), 32'h1);
    checkOutput("first_drop", 32'(drop_count), 32'h1);
    for (int i = 0; i < 300; i++) applyStimulus(32'hFFFF0000 + 32'(i), 1'b0);
    checkOutput("drop_saturated", 32'(drop_count), 32'd255);
    checkOutput("full_level_kept", 32'(fifo_level), 32'd512);

    // Push lands exactly on the LOAD pop of a full FIFO.
    usb_txe_n = 1'b0;
    waitFalls(4, "primer_bytes");
    waitHigh("primer_last_hold");
    repeat (3) @(negedge mclk);
    applyStimulus(32'hBAD0BAD0, 1'b0);
    checkOutput("load_push_dropped", 32'(fifo_level), 32'd511);
    checkOutput("load_overflow", 32'(overflow), 32'h1);

    // Reset during the strobe of byte 2.
    waitFalls(3, "burst_byte2");
    reset = 1'b1;
    @(negedge mclk);
    checkOutput("mid_rst_wr_n", 32'(usb_wr_n), 32'h1);
    checkOutput("mid_rst_oe", 32'(usb_d_oe), 32'h0);
    checkOutput("mid_rst_d_out", 32'(usb_d_out), 32'h0);
    checkOutput("mid_rst_level", 32'(fifo_level), 32'h0);
    checkOutput("mid_rst_overflow", 32'(overflow), 32'h0);
    checkOutput("mid_rst_drops", 32'(drop_count), 32'h0);
    expQ.delete();
    reset = 1'b0;
    repeat (3) @(negedge mclk);

    applyStimulus(32'h55AA1234, 1'b1);
    waitFalls(4, "post_rst_bytes");
    repeat (12) @(negedge mclk);
    checkOutput("post_rst_level", 32'(fifo_level), 32'h0);
    checkOutput("post_rst_queue", 32'(expQ.size()), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
